// File: rtl/mlp_load_sequencer_if.sv
// -----------------------------------------------------------------------------
// mlp_load_sequencer_if
// Bundles the host word stream and the accelerator load bus of the MLP load
// sequencer.
//   s_valid_i / s_data_i / s_ready_o      host word stream (valid/ready)
//   load_en_o / load_type_o / load_payload_o
//   input_load_number_o / layer_number_o / weight_number_o
//                                          beat strobe, data and indices
// Modports:
//   master : host side (drives the stream, observes ready and the load bus)
//   slave  : sequencer side (consumes the stream, drives ready and the load bus)
// -----------------------------------------------------------------------------
interface mlp_load_sequencer_if #(
   parameter int DATA_W = 32
);
   logic              s_valid_i;
   logic [DATA_W-1:0] s_data_i;
   logic              s_ready_o;
   logic              load_en_o;
   logic              load_type_o;
   logic [DATA_W-1:0] load_payload_o;
   logic [3:0]        input_load_number_o;
   logic [2:0]        layer_number_o;
   logic [2:0]        weight_number_o;

   modport master (
      output s_valid_i, s_data_i,
      input  s_ready_o, load_en_o, load_type_o, load_payload_o,
             input_load_number_o, layer_number_o, weight_number_o
   );

   modport slave (
      input  s_valid_i, s_data_i,
      output s_ready_o, load_en_o, load_type_o, load_payload_o,
             input_load_number_o, layer_number_o, weight_number_o
   );
endinterface

// File: rtl/mlp_load_sequencer.sv
// -----------------------------------------------------------------------------
// mlp_load_sequencer
// Feeds MLP_acc_top: takes a flat stream of host words through a small skid
// FIFO and issues them as load beats in the accelerator's fixed order.
//   Layer 0      : per row, 8 input beats then 8 weight beats
//   Layers 1..7  : per row, 8 weight beats
// Ports:
//   clk      clock, rising edge
//   rst_n    asynchronous active-low reset
//   start_i  one-cycle pulse, starts a full load sequence (only from IDLE)
//   bus      host stream in, load beats/indices out (slave modport)
//   busy_o   sequence in progress (cycle after start through the last beat)
//   done_o   one-cycle pulse the cycle after the final beat
// -----------------------------------------------------------------------------
module mlp_load_sequencer #(
   parameter int DATA_W        = 32,
   parameter int FIFO_DEPTH    = 4,
   parameter int N_LAYERS      = 8,
   parameter int N_ROWS        = 16,
   parameter int BEATS_PER_ROW = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start_i,
   mlp_load_sequencer_if.slave   bus,
   output logic                  busy_o,
   output logic                  done_o
);

   // Layer 0 carries inputs and weights, the remaining layers weights only.
   localparam int TOTAL = 2 * N_ROWS * BEATS_PER_ROW + (N_LAYERS - 1) * N_ROWS * BEATS_PER_ROW;
   localparam int ACC_W = $clog2(TOTAL + 1);
   localparam int PTR_W = $clog2(FIFO_DEPTH);

   localparam logic [ACC_W-1:0] TOTAL_C    = ACC_W'(TOTAL);
   localparam logic [PTR_W:0]   DEPTH_C    = (PTR_W + 1)'(FIFO_DEPTH);
   localparam logic [2:0]       BEAT_LAST  = 3'(BEATS_PER_ROW - 1);
   localparam logic [3:0]       ROW_LAST   = 4'(N_ROWS - 1);
   localparam logic [2:0]       LAYER_LAST = 3'(N_LAYERS - 1);

   typedef enum logic [2:0] {IDLE, L0_IN, L0_W, LW, DONE} state_t;

   state_t            state_reg;
   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
   logic [PTR_W:0]    count_reg;
   logic [ACC_W-1:0]  accept_cnt_reg;
   logic [2:0]        beat_reg;
   logic [3:0]        row_reg;
   logic [2:0]        layer_reg;

   logic              load_en_reg;
   logic              load_type_reg;
   logic [DATA_W-1:0] payload_reg;
   logic [3:0]        row_out_reg;
   logic [2:0]        layer_out_reg;
   logic [2:0]        weight_out_reg;
   logic              done_reg;

   logic fifo_full, fifo_empty, in_load, s_ready, push, pop;

   assign fifo_full  = (count_reg == DEPTH_C);
   assign fifo_empty = (count_reg == '0);
   assign in_load    = (state_reg == L0_IN) || (state_reg == L0_W) || (state_reg == LW);
   assign busy_o     = (state_reg != IDLE);
   // Ready is built from registered state only, so it never loops back through s_valid_i.
   // The accept cap stops intake at exactly one sequence worth of words.
   assign s_ready    = busy_o && !fifo_full && (accept_cnt_reg < TOTAL_C);
   assign push       = bus.s_valid_i && s_ready;
   assign pop        = !fifo_empty && in_load;

   assign bus.s_ready_o           = s_ready;
   assign bus.load_en_o           = load_en_reg;
   assign bus.load_type_o         = load_type_reg;
   assign bus.load_payload_o      = payload_reg;
   assign bus.input_load_number_o = row_out_reg;
   assign bus.layer_number_o      = layer_out_reg;
   assign bus.weight_number_o     = weight_out_reg;
   assign done_o                  = done_reg;

   // FIFO storage has no reset so it can map onto RAM; stale words are unreachable
   // once the pointers are cleared.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_reg] <= bus.s_data_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= IDLE;
         wr_ptr_reg     <= '0;
         rd_ptr_reg     <= '0;
         count_reg      <= '0;
         accept_cnt_reg <= '0;
         beat_reg       <= '0;
         row_reg        <= '0;
         layer_reg      <= '0;
         load_en_reg    <= 1'b0;
         load_type_reg  <= 1'b0;
         payload_reg    <= '0;
         row_out_reg    <= '0;
         layer_out_reg  <= '0;
         weight_out_reg <= '0;
         done_reg       <= 1'b0;
      end else begin
         load_en_reg <= 1'b0;
         done_reg    <= 1'b0;

         if (push) begin
            wr_ptr_reg     <= wr_ptr_reg + 1'b1;
            accept_cnt_reg <= accept_cnt_reg + 1'b1;
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         case ({push, pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase

         case (state_reg)
            IDLE: begin
               if (start_i) begin
                  state_reg      <= L0_IN;
                  beat_reg       <= '0;
                  row_reg        <= '0;
                  layer_reg      <= '0;
                  accept_cnt_reg <= '0;
               end
            end
            L0_IN, L0_W, LW: begin
               if (pop) begin
                  // Present the popped word with the indices it was issued under;
                  // the counters below already point at the next beat.
                  load_en_reg    <= 1'b1;
                  load_type_reg  <= (state_reg == L0_IN);
                  payload_reg    <= mem[rd_ptr_reg];
                  row_out_reg    <= row_reg;
                  layer_out_reg  <= layer_reg;
                  weight_out_reg <= (state_reg == L0_IN) ? 3'd0 : beat_reg;

                  if (beat_reg != BEAT_LAST) begin
                     beat_reg <= beat_reg + 1'b1;
                  end else begin
                     beat_reg <= '0;
                     if (state_reg == L0_IN) begin
                        state_reg <= L0_W;
                     end else if (row_reg != ROW_LAST) begin
                        row_reg <= row_reg + 1'b1;
                        if (state_reg == L0_W) begin
                           state_reg <= L0_IN;
                        end
                     end else begin
                        row_reg <= '0;
                        if (layer_reg != LAYER_LAST) begin
                           layer_reg <= layer_reg + 1'b1;
                           state_reg <= LW;
                        end else begin
                           layer_reg <= '0;
                           state_reg <= DONE;
                        end
                     end
                  end
               end
            end
            DONE: begin
               // The final beat is on the bus during this state; done follows it.
               state_reg <= IDLE;
               done_reg  <= 1'b1;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mlp_load_sequencer.sv
module tb_mlp_load_sequencer;

   localparam int TOTAL      = 1152;
   localparam int FIFO_DEPTH = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start_i = 1'b0;
   logic busy_o, done_o;

   mlp_load_sequencer_if #(.DATA_W(32)) bus ();

   mlp_load_sequencer #(
      .DATA_W(32), .FIFO_DEPTH(FIFO_DEPTH), .N_LAYERS(8), .N_ROWS(16), .BEATS_PER_ROW(8)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start_i(start_i), .bus(bus), .busy_o(busy_o), .done_o(done_o)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, req);
   endtask

   typedef struct {
      int         beat;
      logic [2:0] layer;
      logic [3:0] row;
      logic       typ;
      logic [2:0] wn;
   } vec_t;

   vec_t vecs[13];

   logic [2:0]  obs_layer [TOTAL];
   logic [3:0]  obs_row   [TOTAL];
   logic        obs_type  [TOTAL];
   logic [2:0]  obs_wn    [TOTAL];
   logic [31:0] obs_pay   [TOTAL];

   int r_beats, r_mism, r_pay_err, r_hold_err, r_gaps, r_done_cnt, r_done_delay;
   int r_busy_bad, r_max_occ, r_over, r_accepted, r_first;
   bit r_timeout;

   function automatic logic [31:0] word_of(input int idx, input logic [31:0] key);
      return 32'(idx) ^ key;
   endfunction

   // Expected beat position from the beat index alone.
   task automatic model(input int k, output logic [2:0] l, output logic [3:0] r,
                        output logic t, output logic [2:0] w);
      if (k < 256) begin
         l = 3'd0;
         r = 4'(k / 16);
         t = ((k % 16) < 8);
         w = t ? 3'd0 : 3'((k % 16) - 8);
      end else begin
         l = 3'(1 + (k - 256) / 128);
         r = 4'(((k - 256) % 128) / 8);
         t = 1'b0;
         w = 3'(k % 8);
      end
   endtask

   task automatic run_seq(input int pct, input logic [31:0] key, input int poke_cyc, input int reset_beat);
      int sent, beats, last_cyc, occ;
      logic [2:0] el, lw_l, lw_w;
      logic [3:0] er, lw_r;
      logic et, lw_t;
      logic [2:0] ew;
      logic [31:0] lw_p;
      bit reset_hit;
      sent = 0; beats = 0; last_cyc = -1; reset_hit = 0;
      lw_l = '0; lw_w = '0; lw_r = '0; lw_t = 1'b0; lw_p = '0;
      r_mism = 0; r_pay_err = 0; r_hold_err = 0; r_gaps = 0; r_done_cnt = 0;
      r_done_delay = -1; r_busy_bad = 0; r_max_occ = 0; r_over = 0; r_first = -1;
      r_timeout = 1'b1;
      for (int cyc = 0; cyc < 6000; cyc++) begin
         @(negedge clk);
         if (bus.load_en_o) begin
            if (beats < TOTAL) begin
               obs_layer[beats] = bus.layer_number_o;
               obs_row[beats]   = bus.input_load_number_o;
               obs_type[beats]  = bus.load_type_o;
               obs_wn[beats]    = bus.weight_number_o;
               obs_pay[beats]   = bus.load_payload_o;
               model(beats, el, er, et, ew);
               if (el !== bus.layer_number_o || er !== bus.input_load_number_o ||
                   et !== bus.load_type_o || ew !== bus.weight_number_o) r_mism++;
               if (bus.load_payload_o !== word_of(beats, key)) r_pay_err++;
            end
            if (beats == 0) r_first = cyc;
            else if (pct == 100 && cyc != last_cyc + 1) r_gaps++;
            if (!busy_o) r_busy_bad++;
            beats++;
            last_cyc = cyc;
            lw_l = bus.layer_number_o; lw_r = bus.input_load_number_o;
            lw_t = bus.load_type_o; lw_w = bus.weight_number_o; lw_p = bus.load_payload_o;
         end else if (beats > 0 && beats < TOTAL) begin
            if (lw_l !== bus.layer_number_o || lw_r !== bus.input_load_number_o ||
                lw_t !== bus.load_type_o || lw_w !== bus.weight_number_o ||
                lw_p !== bus.load_payload_o) r_hold_err++;
         end
         if (done_o) begin
            r_done_cnt++;
            if (r_done_cnt == 1) begin
               r_done_delay = cyc - last_cyc;
               if (busy_o) r_busy_bad++;
            end
         end
         if (cyc == 1 && !busy_o) r_busy_bad++;
         occ = sent - beats;
         if (occ > r_max_occ) r_max_occ = occ;
         if (reset_beat >= 0 && beats == reset_beat && !reset_hit) begin
            reset_hit = 1;
            check("pre_reset_layer1", 64'(lw_l), 64'd1);
            #1 rst_n = 1'b0;
            #1;
            check("async_rst_load_en", 64'(bus.load_en_o), 64'd0);
            check("async_rst_layer", 64'(bus.layer_number_o), 64'd0);
            check("async_rst_busy_ready", 64'({busy_o, bus.s_ready_o}), 64'd0);
            check("async_rst_payload", 64'(bus.load_payload_o), 64'd0);
            bus.s_valid_i = 1'b0;
            start_i = 1'b0;
            r_timeout = 1'b0;
            break;
         end
         if (r_done_cnt > 0 && cyc >= last_cyc + 4) begin
            r_timeout = 1'b0;
            break;
         end
         start_i       = (cyc == 0 || cyc == poke_cyc);
         bus.s_valid_i = (int'($urandom_range(99)) < pct);
         bus.s_data_i  = word_of(sent, key);
         if (bus.s_valid_i && bus.s_ready_o) begin
            if (sent >= TOTAL) r_over++;
            sent++;
         end
      end
      r_beats = beats;
      r_accepted = sent;
      start_i = 1'b0;
      bus.s_valid_i = 1'b0;
   endtask

   task automatic check_run(input string tag);
      check({tag, "_timeout"}, 64'(r_timeout), 64'd0);
      check({tag, "_beats"}, 64'(r_beats), 64'(TOTAL));
      check({tag, "_accepted"}, 64'(r_accepted), 64'(TOTAL));
      check({tag, "_order_mismatches"}, 64'(r_mism), 64'd0);
      check({tag, "_payload_errors"}, 64'(r_pay_err), 64'd0);
      check({tag, "_hold_errors"}, 64'(r_hold_err), 64'd0);
      check({tag, "_done_pulses"}, 64'(r_done_cnt), 64'd1);
      check({tag, "_done_after_last_beat"}, 64'(r_done_delay), 64'd1);
      check({tag, "_busy_errors"}, 64'(r_busy_bad), 64'd0);
      check({tag, "_fifo_within_depth"}, 64'(r_max_occ <= FIFO_DEPTH), 64'd1);
      check({tag, "_extra_word_accepted"}, 64'(r_over), 64'd0);
   endtask

   initial begin
      vecs[0]  = '{0,    3'd0, 4'd0,  1'b1, 3'd0};
      vecs[1]  = '{7,    3'd0, 4'd0,  1'b1, 3'd0};
      vecs[2]  = '{8,    3'd0, 4'd0,  1'b0, 3'd0};
      vecs[3]  = '{15,   3'd0, 4'd0,  1'b0, 3'd7};
      vecs[4]  = '{16,   3'd0, 4'd1,  1'b1, 3'd0};
      vecs[5]  = '{255,  3'd0, 4'd15, 1'b0, 3'd7};
      vecs[6]  = '{256,  3'd1, 4'd0,  1'b0, 3'd0};
      vecs[7]  = '{263,  3'd1, 4'd0,  1'b0, 3'd7};
      vecs[8]  = '{264,  3'd1, 4'd1,  1'b0, 3'd0};
      vecs[9]  = '{300,  3'd1, 4'd5,  1'b0, 3'd4};
      vecs[10] = '{383,  3'd1, 4'd15, 1'b0, 3'd7};
      vecs[11] = '{384,  3'd2, 4'd0,  1'b0, 3'd0};
      vecs[12] = '{1151, 3'd7, 4'd15, 1'b0, 3'd7};

      // Reset with start_i held high: everything must stay at zero.
      bus.s_valid_i = 1'b1;
      bus.s_data_i  = 32'hDEAD_BEEF;
      rst_n   = 1'b0;
      start_i = 1'b1;
      repeat (5) @(negedge clk);
      check("rst_load_en", 64'(bus.load_en_o), 64'd0);
      check("rst_load_type", 64'(bus.load_type_o), 64'd0);
      check("rst_payload", 64'(bus.load_payload_o), 64'd0);
      check("rst_indices", 64'({bus.input_load_number_o, bus.layer_number_o, bus.weight_number_o}), 64'd0);
      check("rst_busy_done", 64'({busy_o, done_o}), 64'd0);
      check("rst_ready", 64'(bus.s_ready_o), 64'd0);
      start_i = 1'b0;
      bus.s_valid_i = 1'b0;
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("start_in_reset_ignored", 64'({busy_o, bus.s_ready_o}), 64'd0);

      // Full sequence, continuous host words, data = word index.
      run_seq(100, 32'h0, -1, -1);
      check_run("full");
      check("full_no_gaps", 64'(r_gaps), 64'd0);
      check("full_first_beat_latency", 64'(r_first), 64'd3);
      for (int i = 0; i < 13; i++) begin
         int b;
         b = vecs[i].beat;
         check($sformatf("vec_beat%0d_layer", b), 64'(obs_layer[b]), 64'(vecs[i].layer));
         check($sformatf("vec_beat%0d_row", b), 64'(obs_row[b]), 64'(vecs[i].row));
         check($sformatf("vec_beat%0d_type", b), 64'(obs_type[b]), 64'(vecs[i].typ));
         check($sformatf("vec_beat%0d_wnum", b), 64'(obs_wn[b]), 64'(vecs[i].wn));
         check($sformatf("vec_beat%0d_payload", b), 64'(obs_pay[b]), 64'(b));
      end

      // Jittery host, start_i poked mid-sequence.
      run_seq(50, 32'hA5C3_0000, 700, -1);
      check_run("jitter");

      // Fresh start right after done.
      run_seq(100, 32'h0000_5A5A, -1, -1);
      check_run("restart");
      check("restart_beat0_type", 64'(obs_type[0]), 64'd1);
      check("restart_beat0_pos", 64'({obs_layer[0], obs_row[0]}), 64'd0);

      // Asynchronous reset in layer 1, then a clean reload.
      run_seq(100, 32'h0, -1, 300);
      repeat (3) @(negedge clk);
      check("held_reset_idle", 64'({busy_o, done_o, bus.load_en_o}), 64'd0);
      rst_n = 1'b1;
      run_seq(100, 32'h1234_0000, -1, -1);
      check_run("after_reset");
      check("after_reset_beat0", 64'({obs_layer[0], obs_row[0], obs_type[0], obs_wn[0]}), 64'({3'd0, 4'd0, 1'b1, 3'd0}));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
